serial_link_controller: RTL
===========================

Name: serial_link_controller

Overview:
- Host-side counterpart of the system memory serial port.
- Accepts WORD_W-bit words from an external host over a valid/ready handshake and serializes them, MSB first, into the memory. It drives LOAD_MODE and MEM_SERIAL_IN for this.
- On a dump request, drives OUTPUT_MODE and deserializes MEM_SERIAL_OUT back into words for the host.
- Always transfers exactly DATA_SIZE bits per operation, so the memory's circular readout leaves the grid intact.

Parameters:
- DATA_SIZE, 64, grid bit count; must equal the memory's data_size and be a multiple of WORD_W.
- WORD_W, 8, host word width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset; asynchronous, active-high
- START_LOAD  in  1  begin load operation (sampled in IDLE only)
- START_DUMP  in  1  begin dump operation (sampled in IDLE only)
- IN_DATA  in  WORD_W  host word to load
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  controller accepts IN_DATA
- OUT_DATA  out  WORD_W  word read from memory
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  host accepts OUT_DATA
- LOAD_MODE  out  1  to memory LOAD_MODE
- OUTPUT_MODE  out  1  to memory OUTPUT_MODE
- MEM_SERIAL_IN  out  1  to memory SERIAL_IN
- MEM_SERIAL_OUT  in  1  from memory SERIAL_OUT (registered in memory, one cycle after its OUTPUT_MODE cycle)
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse on operation completion

Behaviour:
- Reset: state IDLE; all outputs 0; bit counter, word counter and shift registers cleared. Reset mid-operation aborts immediately with no DONE. Memory contents are then undefined and the host must reload.
- States: IDLE, LOAD_WAIT, LOAD_SHIFT, DUMP_SHIFT, DUMP_DRAIN, DUMP_PRESENT.
- IDLE:
  - START_LOAD goes to LOAD_WAIT.
  - Otherwise START_DUMP goes to DUMP_SHIFT.
  - If both are asserted, load wins.
  - START_* outside IDLE is ignored.
- LOAD_WAIT:
  - IN_READY=1, decoded from the state register.
  - On IN_VALID&IN_READY, latch IN_DATA into the tx shift register and go to LOAD_SHIFT.
  - IN_VALID may stay low indefinitely; the memory holds.
- LOAD_SHIFT:
  - LOAD_MODE=1 for exactly WORD_W cycles.
  - MEM_SERIAL_IN = tx register MSB; the register shifts left each cycle, so word bits go out in order WORD_W-1 down to 0.
  - After WORD_W cycles, increment the word counter. If words == DATA_SIZE/WORD_W, pulse DONE and go to IDLE; else go to LOAD_WAIT.
  - The first host word lands in memory bits [DATA_SIZE-1 : DATA_SIZE-WORD_W].
- Load timing: a handshake in cycle t gives LOAD_MODE high in cycles t+1..t+WORD_W, then IN_READY or DONE in cycle t+WORD_W+1.
- DUMP_SHIFT: OUTPUT_MODE=1 for exactly WORD_W cycles, then DUMP_DRAIN.
- Capture rule:
  - A registered flag records that OUTPUT_MODE was high in the previous cycle.
  - In every cycle with that flag set, shift MEM_SERIAL_OUT into the LSB of the rx register (shift left).
  - Captures therefore happen in the WORD_W cycles following the first OUTPUT_MODE cycle of a word.
- DUMP_DRAIN: OUTPUT_MODE=0; capture the final bit; go to DUMP_PRESENT.
- DUMP_PRESENT:
  - OUT_VALID=1 and OUT_DATA = rx register, both held stable until OUT_READY.
  - On handshake, increment the word counter. If the count is complete, pulse DONE the next cycle and return to IDLE; else return to DUMP_SHIFT.
  - A stalled OUT_READY stalls the memory (OUTPUT_MODE low), so no bits are lost.
- Dump timing: START_DUMP in cycle 0 gives OUTPUT_MODE in cycles 1..WORD_W, captures in cycles 2..WORD_W+1, and OUT_VALID from cycle WORD_W+2.
- Invariants:
  - LOAD_MODE and OUTPUT_MODE are never high together.
  - Total OUTPUT_MODE cycles per dump equal DATA_SIZE, which restores the memory contents.
  - The controller never asserts RUN_MODE; the system's run logic owns it and must be idle while BUSY.
- Widths: word counter is clog2(DATA_SIZE/WORD_W + 1) bits; bit counter is clog2(WORD_W + 1) bits.

Test Plan:
- Bench setup: DATA_SIZE=16, WORD_W=8, connected to the system memory.
- Load 0xA5 then 0x3C -> memory parallel output 0xA53C. LOAD_MODE high exactly 16 cycles total. DONE pulses once; BUSY falls with DONE.
- Dump after that load with OUT_READY tied high -> OUT_DATA 0xA5 then 0x3C. OUT_VALID first rises 10 cycles after START_DUMP. Memory output is still 0xA53C afterward.
- Dump with OUT_READY held low 5 cycles on the first word -> OUTPUT_MODE stays low during the stall. OUT_DATA is held at 0xA5. The second word is 0x3C and memory is unchanged.
- Load with IN_VALID gaps of 3 cycles between words -> LOAD_MODE low during the gaps; final memory 0xA53C.
- START_LOAD and START_DUMP asserted in the same IDLE cycle -> load performed. A START_DUMP pulse during the load is ignored, with no OUTPUT_MODE pulse.
- RESET asserted mid-load after 4 bits -> all outputs 0 immediately, no DONE. A subsequent full load of 0x1234 succeeds.

Source files
------------

// File: rtl/serial_link_controller.sv
// serial_link_controller
// Host-side controller for the system memory serial port. It accepts host
// words over a valid/ready handshake and shifts them MSB first into the
// memory (LOAD_MODE / MEM_SERIAL_IN). On a dump it clocks the memory
// (OUTPUT_MODE) and reassembles MEM_SERIAL_OUT into host words. Every
// operation moves exactly DATA_SIZE bits, so the memory's circular readout
// puts the grid back where it started.

module serial_link_controller #(
   parameter int DATA_SIZE = 64,
   parameter int WORD_W    = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START_LOAD,
   input  logic              START_DUMP,
   input  logic [WORD_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [WORD_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              LOAD_MODE,
   output logic              OUTPUT_MODE,
   output logic              MEM_SERIAL_IN,
   input  logic              MEM_SERIAL_OUT,
   output logic              BUSY,
   output logic              DONE
);

   localparam int NUM_WORDS = DATA_SIZE / WORD_W;
   localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
   localparam int BCNT_W    = $clog2(WORD_W + 1);

   localparam logic [WCNT_W-1:0] WORD_COUNT_DONE = WCNT_W'(NUM_WORDS);
   localparam logic [BCNT_W-1:0] LAST_BIT        = BCNT_W'(WORD_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_WAIT,
      ST_LOAD_SHIFT,
      ST_DUMP_SHIFT,
      ST_DUMP_DRAIN,
      ST_DUMP_PRESENT
   } state_t;

   state_t            state_q,    state_d;
   logic [BCNT_W-1:0] bit_cnt_q,  bit_cnt_d;
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] tx_q,       tx_d;
   logic [WORD_W-1:0] rx_q,       rx_d;
   logic              capture_q,  capture_d;
   logic              done_q,     done_d;

   logic [WCNT_W-1:0] word_cnt_inc;
   logic              last_bit;
   logic              last_word;

   assign word_cnt_inc = word_cnt_q + WCNT_W'(1);
   assign last_bit     = (bit_cnt_q == LAST_BIT);
   assign last_word    = (word_cnt_inc == WORD_COUNT_DONE);

   // State register and datapath flops; reset aborts any operation at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         capture_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         capture_q  <= capture_d;
         done_q     <= done_d;
      end
   end

   // Next-state and datapath updates. The memory registers SERIAL_OUT one
   // cycle after each OUTPUT_MODE cycle, so the rx register samples whenever
   // OUTPUT_MODE was high in the previous cycle, including the drain cycle.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      done_d     = 1'b0;
      capture_d  = (state_q == ST_DUMP_SHIFT);

      if (capture_q) begin
         rx_d = (rx_q << 1) | WORD_W'(MEM_SERIAL_OUT);
      end

      unique case (state_q)
         ST_IDLE: begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            if (START_LOAD) begin
               state_d = ST_LOAD_WAIT;
            end else if (START_DUMP) begin
               state_d = ST_DUMP_SHIFT;
            end
         end

         ST_LOAD_WAIT: begin
            if (IN_VALID) begin
               tx_d      = IN_DATA;
               bit_cnt_d = '0;
               state_d   = ST_LOAD_SHIFT;
            end
         end

         ST_LOAD_SHIFT: begin
            tx_d = tx_q << 1;
            if (last_bit) begin
               bit_cnt_d = '0;
               if (last_word) begin
                  word_cnt_d = '0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  word_cnt_d = word_cnt_inc;
                  state_d    = ST_LOAD_WAIT;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
         end

         ST_DUMP_SHIFT: begin
            if (last_bit) begin
               bit_cnt_d = '0;
               state_d   = ST_DUMP_DRAIN;
            end else begin
               bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
         end

         ST_DUMP_DRAIN: begin
            state_d = ST_DUMP_PRESENT;
         end

         ST_DUMP_PRESENT: begin
            if (OUT_READY) begin
               if (last_word) begin
                  word_cnt_d = '0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  word_cnt_d = word_cnt_inc;
                  state_d    = ST_DUMP_SHIFT;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Mode and handshake outputs decoded straight from the state register so
   // LOAD_MODE and OUTPUT_MODE can never overlap.
   always_comb begin
      IN_READY      = (state_q == ST_LOAD_WAIT);
      LOAD_MODE     = (state_q == ST_LOAD_SHIFT);
      OUTPUT_MODE   = (state_q == ST_DUMP_SHIFT);
      OUT_VALID     = (state_q == ST_DUMP_PRESENT);
      BUSY          = (state_q != ST_IDLE);
      MEM_SERIAL_IN = (state_q == ST_LOAD_SHIFT) && tx_q[WORD_W-1];
   end

   assign OUT_DATA = rx_q;
   assign DONE     = done_q;

endmodule
